// File: rtl/bus_scheduler_if.sv
// rtl/bus_scheduler_if.sv - SPI, video and CPU bus-control signals around bus_scheduler
interface bus_scheduler_if;
  logic spi_valid_i;
  logic spi_ready_o;
  logic video_req_i;
  logic clk8_o;
  logic cpu_clk_o;
  logic cpu_be_o;
  logic cpu_en_o;
  logic spi_en_o;
  logic video_en_o;

  modport master (
    output spi_valid_i, video_req_i,
    input  spi_ready_o, clk8_o, cpu_clk_o, cpu_be_o, cpu_en_o, spi_en_o, video_en_o
  );

  modport slave (
    input  spi_valid_i, video_req_i,
    output spi_ready_o, clk8_o, cpu_clk_o, cpu_be_o, cpu_en_o, spi_en_o, video_en_o
  );
endinterface

// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - eight-slot arbiter granting each 125 ns bus slot to CPU, video or SPI
// Define VIDEO_FETCH_EN to grant video slots; otherwise every slot but 7 is SPI-eligible.
module bus_scheduler #(
  parameter logic [7:0] VIDEO_SLOT_MASK = 8'b0010_0010
) (
  input  logic           clk16_i,
  input  logic           reset_i,
  bus_scheduler_if.slave bus
);

`ifdef VIDEO_FETCH_EN
  localparam logic VIDEO_ON = 1'b1;
`else
  localparam logic VIDEO_ON = 1'b0;
`endif

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_CPU, GRANT_VIDEO, GRANT_SPI} grant_t;

  grant_t     grant_q;
  grant_t     grant_d;
  logic       phase;
  logic [2:0] slot;
  logic [2:0] next_slot;
  logic       spi_valid_q;
  logic       pending;
  logic       pending_d;
  logic       last_spi;
  logic       spi_ready_q;
  logic       cpu_en_q;
  logic       spi_en_q;
  logic       video_en_q;
  logic       cpu_be_q;

  always_comb begin
    grant_d   = grant_q;
    next_slot = slot + 3'd1;
    last_spi  = (grant_q == GRANT_SPI) && phase;
    // A rise while already pending is dropped; a rise on the completing edge re-arms.
    pending_d = (bus.spi_valid_i && !spi_valid_q) || (pending && !last_spi);
    if (phase) begin
      if (next_slot == 3'd7)
        grant_d = GRANT_CPU;
      else if (VIDEO_ON && VIDEO_SLOT_MASK[next_slot] && bus.video_req_i)
        grant_d = GRANT_VIDEO;
      else if (pending && !last_spi)
        grant_d = GRANT_SPI;
      else
        grant_d = GRANT_IDLE;
    end
  end

  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      phase       <= 1'b0;
      slot        <= 3'd0;
      spi_valid_q <= 1'b0;
      pending     <= 1'b0;
      grant_q     <= GRANT_IDLE;
      spi_ready_q <= 1'b0;
      cpu_en_q    <= 1'b0;
      spi_en_q    <= 1'b0;
      video_en_q  <= 1'b0;
      cpu_be_q    <= 1'b1;
    end else begin
      phase       <= !phase;
      if (phase)
        slot <= next_slot;
      spi_valid_q <= bus.spi_valid_i;
      pending     <= pending_d;
      grant_q     <= grant_d;
      spi_ready_q <= last_spi;
      cpu_en_q    <= (grant_d == GRANT_CPU);
      spi_en_q    <= (grant_d == GRANT_SPI);
      video_en_q  <= (grant_d == GRANT_VIDEO);
      cpu_be_q    <= !((grant_d == GRANT_SPI) || (grant_d == GRANT_VIDEO));
    end
  end

  assign bus.clk8_o      = phase;
  assign bus.cpu_clk_o   = slot[2];
  assign bus.cpu_en_o    = cpu_en_q;
  assign bus.spi_en_o    = spi_en_q;
  assign bus.video_en_o  = video_en_q;
  assign bus.cpu_be_o    = cpu_be_q;
  assign bus.spi_ready_o = spi_ready_q;
endmodule
